// File: rtl/tick_gen.sv
// tick_gen: timebase for the LED/PWM stage.
//
// Divides clk into a 1 ms strobe and a 1 s strobe. It also exports the
// millisecond position within the current second, a wrapping seconds count
// and a 1 s square wave. Every output is a flop driven from clk, and no
// clock is derived from clk: consumers use the strobes as clock enables.
//
// Ports
//   clk      main clock
//   rst      synchronous reset, active-high
//   en       count enable; low freezes cyc/ms_cnt/s_cnt/lvl_1s
//   clr      synchronous restart of the timebase (also clears lvl_1s)
//   tick_ms  one-cycle strobe per elapsed millisecond
//   tick_s   one-cycle strobe per elapsed second (coincides with tick_ms)
//   ms_cnt   millisecond within the current second, 0..MS_PER_S-1
//   s_cnt    seconds, 0..S_MAX, wraps to 0
//   s_wrap   one-cycle strobe on the S_MAX -> 0 wrap of s_cnt
//   lvl_1s   toggles on every tick_s (2 s period square wave)
//
// Priority of the controls is rst > clr > en.

module tick_gen #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int MS_PER_S    = 1000,
  parameter int S_MAX       = 999,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic             tick_ms,
  output logic             tick_s,
  output logic [CNT_W-1:0] ms_cnt,
  output logic [CNT_W-1:0] s_cnt,
  output logic             s_wrap,
  output logic             lvl_1s
);

  localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
  // Guard the width so that a bad parameter set reports the check below
  // rather than a zero-width vector.
  localparam int CYC_W = (CYC_PER_MS < 2) ? 1 : $clog2(CYC_PER_MS);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_PER_MS - 1);
  localparam logic [CNT_W-1:0] MS_LAST  = CNT_W'(MS_PER_S - 1);
  localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(S_MAX);

  // Parameter sanity checks, evaluated at elaboration.
  if (CLK_FREQ_HZ % 1000 != 0) begin : g_chk_freq
    $error("tick_gen: CLK_FREQ_HZ must be a multiple of 1000");
  end
  if (CYC_PER_MS < 2) begin : g_chk_cyc
    $error("tick_gen: CLK_FREQ_HZ/1000 must be at least 2");
  end
  if (MS_PER_S < 2) begin : g_chk_ms
    $error("tick_gen: MS_PER_S must be at least 2");
  end
  if (S_MAX < 1) begin : g_chk_s
    $error("tick_gen: S_MAX must be at least 1");
  end
  if ((MS_PER_S - 1) >= (2 ** CNT_W) || S_MAX >= (2 ** CNT_W)) begin : g_chk_w
    $error("tick_gen: CNT_W too small for MS_PER_S-1 or S_MAX");
  end

  logic [CYC_W-1:0] cyc;

  // Each wrap below comes from an explicit terminal-count compare.
  // CYC_PER_MS need not be a power of two, so the bit width alone
  // would not produce the correct period.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      // A partial millisecond is dropped silently, and a terminal count
      // that coincides with rst/clr raises no strobe.
      cyc     <= '0;
      ms_cnt  <= '0;
      s_cnt   <= '0;
      tick_ms <= 1'b0;
      tick_s  <= 1'b0;
      s_wrap  <= 1'b0;
      lvl_1s  <= 1'b0;
    end else begin
      // Strobes default low every edge so that a freeze never stretches them.
      tick_ms <= 1'b0;
      tick_s  <= 1'b0;
      s_wrap  <= 1'b0;
      if (en) begin
        if (cyc != CYC_LAST) begin
          cyc <= cyc + CYC_W'(1);
        end else begin
          cyc     <= '0;
          tick_ms <= 1'b1;
          if (ms_cnt != MS_LAST) begin
            ms_cnt <= ms_cnt + CNT_W'(1);
          end else begin
            ms_cnt <= '0;
            tick_s <= 1'b1;
            lvl_1s <= ~lvl_1s;
            if (s_cnt != S_LAST) begin
              s_cnt <= s_cnt + CNT_W'(1);
            end else begin
              s_cnt  <= '0;
              s_wrap <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
